// File: rtl/kpn_pkg.sv
// Shared constants and elaboration helpers for the KPN channel blocks.
package kpn_pkg;

    localparam int KPN_TOKEN_W = 16;

    // $clog2 that never returns 0, so a counter for a single value still gets a bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kpn_sync_fifo.sv
// First-word-fall-through synchronous FIFO; full/empty derive from the occupancy count.
module kpn_sync_fifo
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_TOKEN_W,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = clog2_min1(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kpn_delay_channel.sv
// KPN delay element: emits DELAY_NUMBER copies of INIT_VALUE, then forwards
// input tokens in order through a FWFT FIFO with valid/ready on both sides.
module kpn_delay_channel
    import kpn_pkg::*;
#(
    parameter int                    DATA_WIDTH   = KPN_TOKEN_W,
    parameter int                    DELAY_NUMBER = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    parameter int                    DEPTH        = 4,
    parameter int                    CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  init_done
);

    localparam int                INIT_W    = clog2_min1(DELAY_NUMBER + 1);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(DELAY_NUMBER);

    logic [INIT_W-1:0]     r_init_cnt;
    logic [DATA_WIDTH-1:0] r_last;
    logic                  w_init_phase;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_fifo_rdata;
    logic                  w_out_fire;
    logic                  w_push;
    logic                  w_fifo_pop;
    logic                  w_init_pop;

    assign w_init_phase = (r_init_cnt != '0);
    assign init_done    = !w_init_phase;

    // in_ready looks only at the FIFO state, never at out_ready.
    assign in_ready   = !w_full;
    assign out_valid  = w_init_phase || !w_empty;
    assign w_out_fire = out_valid && out_ready;

    // A restart cycle swallows any transfer on either side.
    assign w_push     = in_valid && !w_full && !restart;
    assign w_fifo_pop = w_out_fire && !w_init_phase && !restart;
    assign w_init_pop = w_out_fire && w_init_phase && !restart;

    kpn_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (restart),
        .push  (w_push),
        .pop   (w_fifo_pop),
        .wdata (in_data),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            r_init_cnt <= INIT_LOAD;
        end else if (w_init_pop) begin
            r_init_cnt <= r_init_cnt - INIT_W'(1);
        end
    end

    // Last token delivered, so out_data holds steady while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            r_last <= '0;
        end else if (w_fifo_pop) begin
            r_last <= w_fifo_rdata;
        end
    end

    always_comb begin
        out_data = r_last;
        if (w_init_phase) begin
            out_data = INIT_VALUE;
        end else if (!w_empty) begin
            out_data = w_fifo_rdata;
        end
    end

endmodule

// File: tb/tb_kpn_delay_channel.sv
// Directed bench for kpn_delay_channel: three instances covering DELAY=1, DELAY=3 and DELAY=0.
module tb_kpn_delay_channel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_restart, a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_init_done;
    logic [15:0] a_in_data, a_out_data;
    logic [2:0]  a_fifo_count;

    logic        b_restart, b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_init_done;
    logic [15:0] b_in_data, b_out_data;
    logic [2:0]  b_fifo_count;

    logic        c_restart, c_in_valid, c_out_ready, c_in_ready, c_out_valid, c_init_done;
    logic [15:0] c_in_data, c_out_data;
    logic [2:0]  c_fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    kpn_delay_channel #(.DATA_WIDTH(16), .DELAY_NUMBER(1), .INIT_VALUE(16'h0000), .DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .restart(a_restart),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .fifo_count(a_fifo_count), .init_done(a_init_done)
    );

    kpn_delay_channel #(.DATA_WIDTH(16), .DELAY_NUMBER(3), .INIT_VALUE(16'hFFFF), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .restart(b_restart),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .fifo_count(b_fifo_count), .init_done(b_init_done)
    );

    kpn_delay_channel #(.DATA_WIDTH(16), .DELAY_NUMBER(0), .INIT_VALUE(16'h0000), .DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .restart(c_restart),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .fifo_count(c_fifo_count), .init_done(c_init_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_restart = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 16'h0;
        b_restart = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 16'h0;
        c_restart = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = 16'h0;
        step();
        step();

        // Reset state of all three configurations
        chk("a_rst_out_valid", 16'(a_out_valid), 16'h1);
        chk("a_rst_out_data", a_out_data, 16'h0000);
        chk("a_rst_in_ready", 16'(a_in_ready), 16'h1);
        chk("a_rst_count", 16'(a_fifo_count), 16'h0);
        chk("a_rst_init_done", 16'(a_init_done), 16'h0);
        chk("b_rst_out_valid", 16'(b_out_valid), 16'h1);
        chk("b_rst_out_data", b_out_data, 16'hFFFF);
        chk("b_rst_init_done", 16'(b_init_done), 16'h0);
        chk("c_rst_out_valid", 16'(c_out_valid), 16'h0);
        chk("c_rst_out_data", c_out_data, 16'h0000);
        chk("c_rst_init_done", 16'(c_init_done), 16'h1);
        chk("c_rst_in_ready", 16'(c_in_ready), 16'h1);
        rst_n = 1'b1;

        // Defaults: 0x0000 then 0x11, 0x22, 0x33 streaming one per cycle
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h0011;
        step();
        chk("a_s1_init_done", 16'(a_init_done), 16'h1);
        chk("a_s1_count", 16'(a_fifo_count), 16'h1);
        chk("a_s1_out_data", a_out_data, 16'h0011);
        a_in_data = 16'h0022;
        step();
        chk("a_s2_out_data", a_out_data, 16'h0022);
        chk("a_s2_count", 16'(a_fifo_count), 16'h1);
        a_in_data = 16'h0033;
        step();
        chk("a_s3_out_data", a_out_data, 16'h0033);
        a_in_valid = 1'b0;
        step();
        chk("a_s4_out_valid", 16'(a_out_valid), 16'h0);
        chk("a_s4_hold_data", a_out_data, 16'h0033);
        chk("a_s4_count", 16'(a_fifo_count), 16'h0);

        // DELAY=3: fill with back-pressure, fifth token must wait
        b_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b_in_data = 16'(i);
            step();
        end
        b_in_data = 16'h0005;
        step();
        chk("b_full_in_ready", 16'(b_in_ready), 16'h0);
        chk("b_full_count", 16'(b_fifo_count), 16'h4);
        chk("b_full_out_valid", 16'(b_out_valid), 16'h1);
        chk("b_full_out_data", b_out_data, 16'hFFFF);
        b_out_ready = 1'b1;
        step();
        chk("b_init1_data", b_out_data, 16'hFFFF);
        chk("b_init1_count", 16'(b_fifo_count), 16'h4);
        step();
        chk("b_init2_data", b_out_data, 16'hFFFF);
        step();
        chk("b_init3_data", b_out_data, 16'h0001);
        chk("b_init3_done", 16'(b_init_done), 16'h1);
        chk("b_init3_in_ready", 16'(b_in_ready), 16'h0);
        step();
        chk("b_fullpop_count", 16'(b_fifo_count), 16'h3);
        chk("b_fullpop_in_ready", 16'(b_in_ready), 16'h1);
        chk("b_fullpop_data", b_out_data, 16'h0002);
        step();
        chk("b_pushpop_count", 16'(b_fifo_count), 16'h3);
        chk("b_pushpop_data", b_out_data, 16'h0003);
        b_in_valid = 1'b0;
        step();
        chk("b_drain4", b_out_data, 16'h0004);
        step();
        chk("b_drain5", b_out_data, 16'h0005);
        chk("b_drain5_count", 16'(b_fifo_count), 16'h1);
        step();
        chk("b_empty_valid", 16'(b_out_valid), 16'h0);
        chk("b_empty_hold", b_out_data, 16'h0005);

        // DELAY=0: latency of one edge from push to pop
        chk("c_pre_valid", 16'(c_out_valid), 16'h0);
        c_in_valid = 1'b1; c_in_data = 16'h00AB; c_out_ready = 1'b1;
        step();
        chk("c_k_valid", 16'(c_out_valid), 16'h1);
        chk("c_k_data", c_out_data, 16'h00AB);
        chk("c_k_count", 16'(c_fifo_count), 16'h1);
        c_in_valid = 1'b0;
        step();
        chk("c_k1_valid", 16'(c_out_valid), 16'h0);
        chk("c_k1_count", 16'(c_fifo_count), 16'h0);
        chk("c_k1_hold", c_out_data, 16'h00AB);

        // Restart on DELAY=3 with two tokens queued; the restart-cycle push is dropped
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 16'h0044;
        step();
        b_in_data = 16'h0055;
        step();
        chk("b_pre_restart_count", 16'(b_fifo_count), 16'h2);
        b_restart = 1'b1; b_in_data = 16'h0066;
        step();
        b_restart = 1'b0; b_in_valid = 1'b0;
        chk("b_rs_count", 16'(b_fifo_count), 16'h0);
        chk("b_rs_init_done", 16'(b_init_done), 16'h0);
        chk("b_rs_out_data", b_out_data, 16'hFFFF);
        chk("b_rs_out_valid", 16'(b_out_valid), 16'h1);
        b_out_ready = 1'b1;
        step();
        step();
        step();
        chk("b_rs_drop_valid", 16'(b_out_valid), 16'h0);
        chk("b_rs_drop_count", 16'(b_fifo_count), 16'h0);
        chk("b_rs_drop_done", 16'(b_init_done), 16'h1);

        // One-cycle reset mid-operation
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0077;
        step();
        chk("a_pre_rst_count", 16'(a_fifo_count), 16'h1);
        a_in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("a_mid_rst_valid", 16'(a_out_valid), 16'h1);
        chk("a_mid_rst_data", a_out_data, 16'h0000);
        chk("a_mid_rst_count", 16'(a_fifo_count), 16'h0);
        chk("a_mid_rst_done", 16'(a_init_done), 16'h0);
        chk("a_mid_rst_in_ready", 16'(a_in_ready), 16'h1);
        chk("c_mid_rst_valid", 16'(c_out_valid), 16'h0);

        // Wrap-around: tokens 0..9 through DEPTH=4 stay in order
        a_out_ready = 1'b1; a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_in_data = 16'(i);
            step();
            chk("a_wrap_data", a_out_data, 16'(i));
            chk("a_wrap_count", 16'(a_fifo_count), 16'h1);
        end
        a_in_valid = 1'b0;
        step();
        chk("a_wrap_end_valid", 16'(a_out_valid), 16'h0);
        chk("a_wrap_end_hold", a_out_data, 16'h0009);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
